// File: rtl/konane_pkg.sv
// Shared types and constants for the konane turn arbiter.
// Purely declarative: no logic, no latency.
// No flow control of its own.
package konane_pkg;

  // Player identities. The player id doubles as its bit index in 2-bit per-player buses.
  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  // Board geometry: 6x6 board with one selectable flag per cell.
  localparam int BOARD_ROWS  = 6;
  localparam int BOARD_COLS  = 6;
  localparam int BOARD_CELLS = BOARD_ROWS * BOARD_COLS;

  // Signed coordinate width. (-1,-1) is the engine's give-up move.
  localparam int                         COORD_W      = 5;
  localparam logic signed [COORD_W-1:0]  GIVEUP_COORD = 5'sb11111;

  typedef enum logic [1:0] {
    WAIT_OP = 2'd0,  // waiting for the current player's op (or a timeout)
    FWD_OP  = 2'd1,  // presenting the latched op to the engine
    WAIT_RE = 2'd2,  // waiting for the engine's result
    DLV_RE  = 2'd3   // delivering the captured result to the player(s)
  } arb_state_t;

  // One-hot mask selecting a player's bit in a 2-bit per-player bus.
  function automatic logic [1:0] player_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/konane_idle_timer.sv
// Saturating idle counter: counts enabled cycles up to TIMEOUT_CYCLES and holds there.
// done is a decode of the registered count and rises TIMEOUT_CYCLES enabled cycles after a clear.
// No backpressure; clr has priority over en.
// Ports: clk, rst (async active-high), en (count this cycle), clr (return to zero), done (count at limit).
module konane_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int                CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]     LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == LIMIT);

endmodule

// File: rtl/konane_turn_arbiter.sv
// Turn arbiter between two konane players and the game engine: gates ops by turn and routes results back.
// Latency: the op reaches the engine 1 cycle after acceptance; the result is offered to players 1 cycle after eng_re_valid.
// Backpressure: each stage holds until its handshake completes; only the current player's op is ever acknowledged.
// Ports: p_op_* / p_re_* are the per-player op and result channels (bit k = player k).
//        eng_op_* / eng_re_* are the engine handshake pair; re_* are the captured result fields.
//        cur_player, turn_count, game_count, winner, game_over and stall report game status.
module konane_turn_arbiter
  import konane_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  // player op channels
  input  logic [1:0]               p_op_valid,
  output logic [1:0]               p_op_ready,
  input  logic [2*COORD_W-1:0]     p_op_i,
  input  logic [2*COORD_W-1:0]     p_op_j,
  // player result channels
  output logic [1:0]               p_re_valid,
  input  logic [1:0]               p_re_ready,
  output logic                     re_is_finished,
  output logic                     re_next_player_id,
  output logic                     re_player_can_giveup,
  output logic [BOARD_CELLS-1:0]   re_selectable,
  // engine op channel
  output logic                     eng_op_valid,
  input  logic                     eng_op_ready,
  output logic [COORD_W-1:0]       eng_op_i,
  output logic [COORD_W-1:0]       eng_op_j,
  // engine result channel
  input  logic                     eng_re_valid,
  output logic                     eng_re_ready,
  input  logic                     eng_re_is_finished,
  input  logic                     eng_re_next_player_id,
  input  logic                     eng_re_player_can_giveup,
  input  logic [BOARD_CELLS-1:0]   eng_re_selectable,
  // game status
  output logic                     cur_player,
  output logic [CNT_W-1:0]         turn_count,
  output logic [CNT_W-1:0]         game_count,
  output logic                     winner,
  output logic                     game_over,
  output logic                     stall
);

  arb_state_t                  state;
  logic                        can_giveup_r;
  logic signed [COORD_W-1:0]   op_i_r;
  logic signed [COORD_W-1:0]   op_j_r;
  logic [1:0]                  re_vld_r;
  logic                        game_over_r;
  logic                        timer_done;
  logic [1:0]                  re_left;
  logic [COORD_W-1:0]          sel_i;
  logic [COORD_W-1:0]          sel_j;

  // Idle timer runs only while waiting for an op; any other state holds it at zero.
  konane_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state == WAIT_OP),
    .clr  (state != WAIT_OP),
    .done (timer_done)
  );

  // Coordinates of whichever player currently owns the turn.
  assign sel_i = cur_player ? p_op_i[2*COORD_W-1:COORD_W] : p_op_i[COORD_W-1:0];
  assign sel_j = cur_player ? p_op_j[2*COORD_W-1:COORD_W] : p_op_j[COORD_W-1:0];

  // Result bits still outstanding after this cycle's player handshakes.
  assign re_left = re_vld_r & ~p_re_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= WAIT_OP;
      cur_player           <= BLACK;
      can_giveup_r         <= 1'b0;
      op_i_r               <= '0;
      op_j_r               <= '0;
      re_vld_r             <= 2'b00;
      re_is_finished       <= 1'b0;
      re_next_player_id    <= 1'b0;
      re_player_can_giveup <= 1'b0;
      re_selectable        <= '0;
      turn_count           <= '0;
      game_count           <= '0;
      winner               <= 1'b0;
      game_over_r          <= 1'b0;
    end else begin
      game_over_r <= 1'b0;
      case (state)
        WAIT_OP: begin
          // A real op always beats the automatic give-up.
          if (p_op_valid[cur_player]) begin
            op_i_r <= sel_i;
            op_j_r <= sel_j;
            state  <= FWD_OP;
          end else if (timer_done && can_giveup_r) begin
            op_i_r <= GIVEUP_COORD;
            op_j_r <= GIVEUP_COORD;
            state  <= FWD_OP;
          end
        end

        FWD_OP: begin
          if (eng_op_ready) begin
            state <= WAIT_RE;
          end
        end

        WAIT_RE: begin
          if (eng_re_valid) begin
            re_is_finished       <= eng_re_is_finished;
            re_next_player_id    <= eng_re_next_player_id;
            re_player_can_giveup <= eng_re_player_can_giveup;
            re_selectable        <= eng_re_selectable;
            // A finished game is announced to both players; otherwise only the mover sees it.
            re_vld_r             <= eng_re_is_finished ? 2'b11 : player_mask(cur_player);
            state                <= DLV_RE;
          end
        end

        DLV_RE: begin
          if (re_is_finished) begin
            re_vld_r <= re_left;
            if (re_left == 2'b00) begin
              // cur_player is still the mover of the finishing op.
              winner       <= cur_player;
              game_over_r  <= 1'b1;
              if (game_count != {CNT_W{1'b1}}) begin
                game_count <= game_count + 1'b1;
              end
              turn_count   <= '0;
              cur_player   <= BLACK;
              can_giveup_r <= 1'b0;
              state        <= WAIT_OP;
            end
          end else if (p_re_ready[cur_player]) begin
            re_vld_r     <= 2'b00;
            can_giveup_r <= re_player_can_giveup;
            // The same player keeps the turn during a continued jump; only a hand-over completes a turn.
            if (re_next_player_id != cur_player) begin
              if (turn_count != {CNT_W{1'b1}}) begin
                turn_count <= turn_count + 1'b1;
              end
              cur_player <= re_next_player_id;
            end
            state <= WAIT_OP;
          end
        end

        default: state <= WAIT_OP;
      endcase
    end
  end

  assign p_op_ready   = (state == WAIT_OP) ? player_mask(cur_player) : 2'b00;
  assign eng_op_valid = (state == FWD_OP);
  assign eng_op_i     = op_i_r;
  assign eng_op_j     = op_j_r;
  assign eng_re_ready = (state == WAIT_RE);
  assign p_re_valid   = re_vld_r;
  assign game_over    = game_over_r;
  // Timed out but the engine has not offered a give-up: the player is simply stuck.
  assign stall        = (state == WAIT_OP) && timer_done && !can_giveup_r;

endmodule

// File: tb/tb_konane_turn_arbiter.sv
module tb_konane_turn_arbiter;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  p_op_valid;
  logic [1:0]  p_op_ready;
  logic [9:0]  p_op_i;
  logic [9:0]  p_op_j;
  logic [1:0]  p_re_valid;
  logic [1:0]  p_re_ready;
  logic        re_is_finished;
  logic        re_next_player_id;
  logic        re_player_can_giveup;
  logic [35:0] re_selectable;
  logic        eng_op_valid;
  logic        eng_op_ready;
  logic [4:0]  eng_op_i;
  logic [4:0]  eng_op_j;
  logic        eng_re_valid;
  logic        eng_re_ready;
  logic        eng_re_is_finished;
  logic        eng_re_next_player_id;
  logic        eng_re_player_can_giveup;
  logic [35:0] eng_re_selectable;
  logic        cur_player;
  logic [7:0]  turn_count;
  logic [7:0]  game_count;
  logic        winner;
  logic        game_over;
  logic        stall;

  int checks = 0;
  int errors = 0;

  // Reference model of the game status, updated from the rules of play.
  logic       m_cur;
  logic [7:0] m_turn;
  logic [7:0] m_game;
  logic       m_cg;
  logic       m_winner;

  always #5 clk = ~clk;

  konane_turn_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .p_op_valid(p_op_valid), .p_op_ready(p_op_ready), .p_op_i(p_op_i), .p_op_j(p_op_j),
    .p_re_valid(p_re_valid), .p_re_ready(p_re_ready),
    .re_is_finished(re_is_finished), .re_next_player_id(re_next_player_id),
    .re_player_can_giveup(re_player_can_giveup), .re_selectable(re_selectable),
    .eng_op_valid(eng_op_valid), .eng_op_ready(eng_op_ready), .eng_op_i(eng_op_i), .eng_op_j(eng_op_j),
    .eng_re_valid(eng_re_valid), .eng_re_ready(eng_re_ready),
    .eng_re_is_finished(eng_re_is_finished), .eng_re_next_player_id(eng_re_next_player_id),
    .eng_re_player_can_giveup(eng_re_player_can_giveup), .eng_re_selectable(eng_re_selectable),
    .cur_player(cur_player), .turn_count(turn_count), .game_count(game_count),
    .winner(winner), .game_over(game_over), .stall(stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] mask_of(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [35:0] rand_sel();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  // Game rules applied to one delivered result.
  task automatic apply_model(input logic fin, input logic nxt, input logic cg);
    if (fin) begin
      m_winner = m_cur;
      if (m_game != 8'hFF) m_game = m_game + 8'd1;
      m_turn = 8'd0;
      m_cur  = 1'b0;
      m_cg   = 1'b0;
    end else begin
      m_cg = cg;
      if (nxt != m_cur) begin
        if (m_turn != 8'hFF) m_turn = m_turn + 8'd1;
        m_cur = nxt;
      end
    end
  endtask

  // Player p offers an op; optionally the other player also raises valid at the same time.
  task automatic player_send(input logic p, input logic [4:0] oi, input logic [4:0] oj,
                             input bit noise, output bit ok);
    ok = 0;
    if (p) begin p_op_i[9:5] = oi; p_op_j[9:5] = oj; end
    else   begin p_op_i[4:0] = oi; p_op_j[4:0] = oj; end
    p_op_valid = mask_of(p) | (noise ? mask_of(~p) : 2'b00);
    for (int c = 0; c < 10 && !ok; c++) begin
      if (p_op_ready[p]) ok = 1;
      step();
    end
    p_op_valid = 2'b00;
  endtask

  // Engine side: accept one op, then return one result.
  task automatic engine_cycle(input logic fin, input logic nxt, input logic cg, input logic [35:0] sel,
                              output logic [4:0] ei, output logic [4:0] ej, output bit ok);
    bit got;
    ok = 0; got = 0; ei = '0; ej = '0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (eng_op_valid) got = 1;
      else step();
    end
    if (got) begin
      ei = eng_op_i; ej = eng_op_j;
      eng_op_ready = 1'b1;
      step();
      eng_op_ready = 1'b0;
      eng_re_is_finished = fin; eng_re_next_player_id = nxt;
      eng_re_player_can_giveup = cg; eng_re_selectable = sel;
      eng_re_valid = 1'b1;
      for (int c = 0; c < 20 && !ok; c++) begin
        if (eng_re_ready) ok = 1;
        step();
      end
      eng_re_valid = 1'b0;
      // Scramble the engine bus so held re_* values are really held.
      eng_re_selectable = rand_sel();
      eng_re_is_finished = 1'($urandom); eng_re_next_player_id = 1'($urandom);
      eng_re_player_can_giveup = 1'($urandom);
    end
  endtask

  // Players take the result; ready of player k rises d_k cycles into delivery.
  task automatic deliver(input int d0, input int d1, output logic [1:0] pv0, output logic [1:0] pv1,
                         output int go_cnt, output bit go_last, output bit ok);
    ok = 0; go_cnt = 0; go_last = 0; pv0 = p_re_valid; pv1 = 2'b00;
    for (int c = 0; c < 100 && !ok; c++) begin
      p_re_ready[0] = (c >= d0);
      p_re_ready[1] = (c >= d1);
      step();
      if (c == 0) pv1 = p_re_valid;
      if (game_over) go_cnt++;
      if (p_re_valid == 2'b00) begin ok = 1; go_last = game_over; end
    end
    p_re_ready = 2'b00;
  endtask

  task automatic test_reset();
    checks++; if (p_op_ready !== 2'b01) begin errors++; $display("FAIL reset_p_op_ready: got %b exp 01", p_op_ready); end
    checks++; if (eng_op_valid !== 1'b0 || eng_re_ready !== 1'b0) begin errors++; $display("FAIL reset_eng: op_valid %b re_ready %b exp 0 0", eng_op_valid, eng_re_ready); end
    checks++; if (p_re_valid !== 2'b00) begin errors++; $display("FAIL reset_p_re_valid: got %b exp 00", p_re_valid); end
    checks++; if ({cur_player, winner, game_over, stall} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {cur_player, winner, game_over, stall}); end
    checks++; if (turn_count !== 8'd0 || game_count !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", turn_count, game_count); end
    checks++; if ({re_is_finished, re_next_player_id, re_player_can_giveup, re_selectable} !== 39'd0) begin errors++; $display("FAIL reset_re: got %h exp 0", {re_is_finished, re_next_player_id, re_player_can_giveup, re_selectable}); end
  endtask

  task automatic test_wrong_player();
    int bad;
    bit ok1, ok2, ok3, gl;
    logic [4:0] ei, ej;
    logic [1:0] pv0, pv1;
    logic [35:0] sel;
    int gc;
    bad = 0;
    p_op_i[9:5] = 5'd2; p_op_j[9:5] = 5'd2; p_op_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      if (p_op_ready !== 2'b01 || eng_op_valid !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrong_player_ignored: got %0d bad cycles exp 0", bad); end
    sel = rand_sel();
    player_send(1'b0, 5'd2, 5'd2, 1'b1, ok1);
    engine_cycle(1'b0, 1'b1, 1'b0, sel, ei, ej, ok2);
    deliver(1, 0, pv0, pv1, gc, gl, ok3);
    apply_model(1'b0, 1'b1, 1'b0);
    checks++; if ({ok1, ok2, ok3} !== 3'b111) begin errors++; $display("FAIL first_move_handshake: got %b exp 111", {ok1, ok2, ok3}); end
    checks++; if (ei !== 5'd2 || ej !== 5'd2) begin errors++; $display("FAIL first_move_eng_op: got (%0d,%0d) exp (2,2)", ei, ej); end
    checks++; if (pv0 !== 2'b01 || pv1 !== 2'b01) begin errors++; $display("FAIL first_move_route: got %b,%b exp 01,01", pv0, pv1); end
    checks++; if (cur_player !== m_cur || turn_count !== m_turn) begin errors++; $display("FAIL first_move_turn: got cur %b turn %0d exp %b %0d", cur_player, turn_count, m_cur, m_turn); end
    checks++; if (p_op_ready !== 2'b10) begin errors++; $display("FAIL first_move_p_op_ready: got %b exp 10", p_op_ready); end
    checks++; if (re_selectable !== sel || re_next_player_id !== 1'b1) begin errors++; $display("FAIL first_move_re_hold: got %h/%b exp %h/1", re_selectable, re_next_player_id, sel); end
  endtask

  task automatic test_giveup();
    bit ok1, ok2, ok3, ok4, gl, stall_seen;
    logic [4:0] ei, ej;
    logic [1:0] pv0, pv1;
    int gc, waited;
    // WHITE continues a jump and is allowed to give up, then goes idle.
    player_send(m_cur, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, ok1);
    engine_cycle(1'b0, m_cur, 1'b1, rand_sel(), ei, ej, ok2);
    deliver($urandom_range(0, 3), $urandom_range(0, 3), pv0, pv1, gc, gl, ok3);
    apply_model(1'b0, m_cur, 1'b1);
    checks++; if ({ok1, ok2, ok3} !== 3'b111) begin errors++; $display("FAIL giveup_setup_handshake: got %b exp 111", {ok1, ok2, ok3}); end
    checks++; if (turn_count !== m_turn || cur_player !== m_cur) begin errors++; $display("FAIL same_player_no_turn: got cur %b turn %0d exp %b %0d", cur_player, turn_count, m_cur, m_turn); end
    waited = 0; stall_seen = 0;
    while (!eng_op_valid && waited < TO + 20) begin
      if (stall) stall_seen = 1;
      step();
      waited++;
    end
    checks++; if (waited < TO || waited > TO + 2) begin errors++; $display("FAIL giveup_delay: got %0d cycles exp %0d..%0d", waited, TO, TO + 2); end
    checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL giveup_stall: got %b exp 0", stall_seen); end
    engine_cycle(1'b0, ~m_cur, 1'b0, rand_sel(), ei, ej, ok4);
    checks++; if (ok4 !== 1'b1 || ei !== 5'b11111 || ej !== 5'b11111) begin errors++; $display("FAIL giveup_eng_op: got ok %b (%0d,%0d) exp 1 (31,31)", ok4, ei, ej); end
    deliver(0, 0, pv0, pv1, gc, gl, ok3);
    apply_model(1'b0, ~m_cur, 1'b0);
    checks++; if (cur_player !== m_cur || turn_count !== m_turn) begin errors++; $display("FAIL giveup_turn: got cur %b turn %0d exp %b %0d", cur_player, turn_count, m_cur, m_turn); end
  endtask

  task automatic test_stall();
    bit ok1, ok2, ok3, gl;
    logic [4:0] oi, oj, ei, ej;
    logic [1:0] pv0, pv1;
    logic nxt;
    int gc, fwd;
    logic early;
    fwd = 0; early = 1'bx;
    for (int c = 0; c < TO + 5; c++) begin
      if (c == TO - 1) early = stall;
      if (eng_op_valid) fwd++;
      step();
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL stall_early: got %b exp 0", early); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_set: got %b exp 1", stall); end
    checks++; if (fwd != 0 || eng_op_valid !== 1'b0) begin errors++; $display("FAIL stall_no_op: got %0d op cycles exp 0", fwd); end
    oi = 5'($urandom_range(0, 31)); oj = 5'($urandom_range(0, 31)); nxt = 1'($urandom);
    player_send(m_cur, oi, oj, 1'b0, ok1);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b exp 0", stall); end
    engine_cycle(1'b0, nxt, 1'b0, rand_sel(), ei, ej, ok2);
    checks++; if ({ok1, ok2} !== 2'b11 || ei !== oi || ej !== oj) begin errors++; $display("FAIL stall_forward: got (%0d,%0d) exp (%0d,%0d)", ei, ej, oi, oj); end
    deliver(0, 0, pv0, pv1, gc, gl, ok3);
    apply_model(1'b0, nxt, 1'b0);
  endtask

  task automatic test_hold();
    bit ok1, ok2, ok3, gl;
    logic [4:0] oi, oj, ei, ej;
    logic [1:0] pv0, pv1;
    int gc;
    oi = 5'($urandom_range(0, 31)); oj = 5'($urandom_range(0, 31));
    player_send(m_cur, oi, oj, 1'b0, ok1);
    for (int c = 0; c < 5; c++) begin
      p_op_i = 10'($urandom); p_op_j = 10'($urandom); p_op_valid = 2'($urandom);
      checks++; if (eng_op_valid !== 1'b1 || eng_op_i !== oi || eng_op_j !== oj) begin errors++; $display("FAIL hold_cycle%0d: got %b (%0d,%0d) exp 1 (%0d,%0d)", c, eng_op_valid, eng_op_i, eng_op_j, oi, oj); end
      step();
    end
    p_op_valid = 2'b00;
    engine_cycle(1'b0, m_cur, 1'b0, rand_sel(), ei, ej, ok2);
    checks++; if ({ok1, ok2} !== 2'b11 || ei !== oi || ej !== oj) begin errors++; $display("FAIL hold_accept: got (%0d,%0d) exp (%0d,%0d)", ei, ej, oi, oj); end
    deliver(0, 0, pv0, pv1, gc, gl, ok3);
    apply_model(1'b0, m_cur, 1'b0);
  endtask

  task automatic test_finish();
    bit ok1, ok2, ok3, gl;
    logic [4:0] ei, ej;
    logic [1:0] pv0, pv1;
    int gc;
    if (m_cur != 1'b1) begin
      player_send(m_cur, 5'd1, 5'd1, 1'b0, ok1);
      engine_cycle(1'b0, 1'b1, 1'b0, rand_sel(), ei, ej, ok2);
      deliver(0, 0, pv0, pv1, gc, gl, ok3);
      apply_model(1'b0, 1'b1, 1'b0);
    end
    checks++; if (cur_player !== 1'b1) begin errors++; $display("FAIL finish_setup: got cur %b exp 1", cur_player); end
    player_send(1'b1, 5'd3, 5'd4, 1'b0, ok1);
    engine_cycle(1'b1, 1'b0, 1'b1, rand_sel(), ei, ej, ok2);
    deliver(0, 3, pv0, pv1, gc, gl, ok3);
    apply_model(1'b1, 1'b0, 1'b1);
    checks++; if ({ok1, ok2, ok3} !== 3'b111) begin errors++; $display("FAIL finish_handshake: got %b exp 111", {ok1, ok2, ok3}); end
    checks++; if (pv0 !== 2'b11 || pv1 !== 2'b10) begin errors++; $display("FAIL finish_valid: got %b,%b exp 11,10", pv0, pv1); end
    checks++; if (gc != 1 || gl !== 1'b1) begin errors++; $display("FAIL finish_pulse: got %0d pulses last %b exp 1 1", gc, gl); end
    step();
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL finish_pulse_width: got %b exp 0", game_over); end
    checks++; if (winner !== 1'b1 || game_count !== m_game) begin errors++; $display("FAIL finish_winner: got w %b games %0d exp 1 %0d", winner, game_count, m_game); end
    checks++; if (cur_player !== 1'b0 || turn_count !== 8'd0 || p_op_ready !== 2'b01) begin errors++; $display("FAIL finish_restart: got cur %b turn %0d rdy %b exp 0 0 01", cur_player, turn_count, p_op_ready); end
  endtask

  task automatic test_random();
    bit ok1, ok2, ok3, gl;
    logic [4:0] oi, oj, ei, ej;
    logic [1:0] pv0, pv1, exp_pv;
    logic fin, nxt, cg, mover;
    logic [35:0] sel;
    int gc;
    for (int n = 0; n < 40; n++) begin
      mover = m_cur;
      oi = 5'($urandom_range(0, 31)); oj = 5'($urandom_range(0, 31));
      fin = ($urandom_range(0, 7) == 0); nxt = 1'($urandom); cg = 1'($urandom); sel = rand_sel();
      player_send(mover, oi, oj, 1'($urandom), ok1);
      engine_cycle(fin, nxt, cg, sel, ei, ej, ok2);
      deliver($urandom_range(0, 3), $urandom_range(0, 3), pv0, pv1, gc, gl, ok3);
      apply_model(fin, nxt, cg);
      exp_pv = fin ? 2'b11 : mask_of(mover);
      checks++; if ({ok1, ok2, ok3} !== 3'b111) begin errors++; $display("FAIL rnd%0d_handshake: got %b exp 111", n, {ok1, ok2, ok3}); end
      checks++; if (ei !== oi || ej !== oj) begin errors++; $display("FAIL rnd%0d_eng_op: got (%0d,%0d) exp (%0d,%0d)", n, ei, ej, oi, oj); end
      checks++; if (pv0 !== exp_pv) begin errors++; $display("FAIL rnd%0d_route: got %b exp %b", n, pv0, exp_pv); end
      checks++; if (gc != int'(fin)) begin errors++; $display("FAIL rnd%0d_game_over: got %0d pulses exp %0d", n, gc, fin); end
      checks++; if ({re_is_finished, re_next_player_id, re_player_can_giveup, re_selectable} !== {fin, nxt, cg, sel}) begin errors++; $display("FAIL rnd%0d_re: got %h exp %h", n, {re_is_finished, re_next_player_id, re_player_can_giveup, re_selectable}, {fin, nxt, cg, sel}); end
      checks++; if (cur_player !== m_cur || turn_count !== m_turn || game_count !== m_game || winner !== m_winner) begin errors++; $display("FAIL rnd%0d_status: got %b/%0d/%0d/%b exp %b/%0d/%0d/%b", n, cur_player, turn_count, game_count, winner, m_cur, m_turn, m_game, m_winner); end
      checks++; if (p_op_ready !== mask_of(m_cur)) begin errors++; $display("FAIL rnd%0d_p_op_ready: got %b exp %b", n, p_op_ready, mask_of(m_cur)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    p_op_valid = 2'b00; p_op_i = '0; p_op_j = '0; p_re_ready = 2'b00;
    eng_op_ready = 1'b0; eng_re_valid = 1'b0;
    eng_re_is_finished = 1'b0; eng_re_next_player_id = 1'b0;
    eng_re_player_can_giveup = 1'b0; eng_re_selectable = '0;
    m_cur = 1'b0; m_turn = 8'd0; m_game = 8'd0; m_cg = 1'b0; m_winner = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    test_reset();
    test_wrong_player();
    test_giveup();
    test_stall();
    test_hold();
    test_finish();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
